sub_shift_rows: RTL and testbench

Iterative, low-area SubBytes + ShiftRows stage of the AES-128 round datapath, sitting directly upstream of the column-serial MixColumns stage. It processes one 32-bit output column per cycle through a single 4-byte S-box slice, so a 128-bit block takes four cycles. It uses the same start/ready pulse handshake and column-major byte ordering as the MixColumns stage. For decryption it applies InvShiftRows and InvSubBytes.

---
 rtl/sub_shift_rows_pkg.sv | 64 ++++++
 rtl/sub_shift_rows_sbox_word.sv | 15 +
 rtl/sub_shift_rows.sv | 96 +++++++++
 tb/tb_sub_shift_rows.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_shift_rows_pkg.sv
// Shared AES datapath definitions: column-state encodings, column-major byte
// addressing and the GF(2^8) arithmetic behind the forward/inverse S-box.
package sub_shift_rows_pkg;

  // The state value doubles as the index of the column being produced.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } state_e;

  // Byte (row, col) of a 128-bit block; column 0 / row 0 is the top byte.
  function automatic logic [7:0] state_byte(input logic [127:0] blk,
                                            input logic [1:0]   col,
                                            input logic [1:0]   row);
    logic [127:0] shifted;
    shifted = blk << {col, row, 3'b000};
    return shifted[127:120];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] v;
    v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

endpackage

// File: rtl/sub_shift_rows_sbox_word.sv
// One 32-bit S-box slice: four independent byte lookups, forward or inverse.
module sbox_word
  import sub_shift_rows_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic        decrypt_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign word_o[8*b +: 8] = decrypt_i ? sbox_inv(word_i[8*b +: 8])
                                        : sbox_fwd(word_i[8*b +: 8]);
  end

endmodule

// File: rtl/sub_shift_rows.sv
// Column-serial AES SubBytes+ShiftRows (or their inverses): one output column
// per cycle through a single sbox_word slice, result after four cycles.
module sub_shift_rows
  import sub_shift_rows_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         decrypt_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  state_e         state_q, state_d;
  logic           dec_q, dec_d;
  logic [127:32]  data_reg_q, data_reg_d;
  logic [127:0]   data_o_q, data_o_d;
  logic           ready_q, ready_d;

  logic [1:0]     col_idx;
  logic           dir;
  logic [1:0]     src_col;
  logic [31:0]    gather_word;
  logic [31:0]    sub_word;

  // The direction must come straight from decrypt_i in IDLE since column 0 is
  // produced in the same cycle that dec_q is captured.
  always_comb begin
    col_idx     = state_q;
    dir         = (state_q == IDLE) ? decrypt_i : dec_q;
    src_col     = 2'd0;
    gather_word = 32'h0;
    for (int r = 0; r < 4; r++) begin
      src_col = dir ? (col_idx - 2'(r)) : (col_idx + 2'(r));
      gather_word[31-8*r -: 8] = state_byte(data_i, src_col, 2'(r));
    end
  end

  sbox_word u_sbox_word (
    .word_i   (gather_word),
    .decrypt_i(dir),
    .word_o   (sub_word)
  );

  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    data_reg_d = data_reg_q;
    data_o_d   = data_o_q;
    ready_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dec_d               = decrypt_i;
          data_reg_d[127:96]  = sub_word;
          state_d             = COL1;
        end
      end
      COL1: begin
        data_reg_d[95:64] = sub_word;
        state_d           = COL2;
      end
      COL2: begin
        data_reg_d[63:32] = sub_word;
        state_d           = COL3;
      end
      COL3: begin
        data_o_d = {data_reg_q, sub_word};
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dec_q      <= 1'b0;
      data_reg_q <= '0;
      data_o_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      data_reg_q <= data_reg_d;
      data_o_q   <= data_o_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_o_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Self-checking bench for sub_shift_rows: directed vector table, handshake
// corner cases, and random blocks against a table-generated reference.
`timescale 1ns/1ps
module tb_sub_shift_rows;

  logic         clk;
  logic         reset;
  logic         decrypt_i;
  logic         start_i;
  logic [127:0] data_i;
  logic         ready_o;
  logic [127:0] data_o;

  int total;
  int bad;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  typedef struct packed {
    logic [127:0] din;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] CNT_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CNT_OUT  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

  sub_shift_rows dut (
    .clk      (clk),
    .reset    (reset),
    .decrypt_i(decrypt_i),
    .start_i  (start_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .data_o   (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Reference S-box built by walking generator 3 and its inverse together.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model(input logic [127:0] din, input logic dec);
    logic [127:0] res;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = dec ? ((c - r + 4) % 4) : ((c + r) % 4);
        res[127-32*c-8*r -: 8] = dec ? inv_t[din[127-32*src-8*r -: 8]]
                                     : sbox_t[din[127-32*src-8*r -: 8]];
      end
    end
    return res;
  endfunction

  task automatic check_output(input string name, input logic [127:0] got,
                              input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issues one block and returns in the cycle ready_o is seen high.
  task automatic apply_stimulus(input logic [127:0] din, input logic dec,
                                input string name, output logic [127:0] res);
    int cycles;
    @(negedge clk);
    data_i    = din;
    decrypt_i = dec;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cycles  = 1;
    while (!ready_o && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_output({name, " latency"}, 128'(cycles), 128'd4);
    res = data_o;
  endtask

  initial begin
    logic [127:0] res, res2, rnd, prev;
    int pulses, cycles;

    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    decrypt_i = 1'b0;
    start_i   = 1'b0;
    data_i    = '0;
    build_tables();

    vecs[0] = '{din: FIPS_IN,         dec: 1'b0, exp: FIPS_OUT};
    vecs[1] = '{din: FIPS_OUT,        dec: 1'b1, exp: FIPS_IN};
    vecs[2] = '{din: '0,              dec: 1'b0, exp: {16{8'h63}}};
    vecs[3] = '{din: '0,              dec: 1'b1, exp: {16{8'h52}}};
    vecs[4] = '{din: {16{8'hff}},     dec: 1'b0, exp: {16{8'h16}}};
    vecs[5] = '{din: {16{8'hff}},     dec: 1'b1, exp: {16{8'h7d}}};
    vecs[6] = '{din: CNT_IN,          dec: 1'b0, exp: CNT_OUT};
    vecs[7] = '{din: CNT_OUT,         dec: 1'b1, exp: CNT_IN};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset ready", 128'(ready_o), 128'd0);
    check_output("reset data", data_o, '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].din, vecs[i].dec, $sformatf("vec%0d", i), res);
      check_output($sformatf("vec%0d data", i), res, vecs[i].exp);
      @(posedge clk); #1;
      check_output($sformatf("vec%0d pulse width", i), 128'(ready_o), 128'd0);
      check_output($sformatf("vec%0d hold", i), data_o, vecs[i].exp);
    end

    // decrypt_i wiggled while the block is in flight must not matter
    @(negedge clk);
    data_i    = '0;
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      decrypt_i = ~decrypt_i;
      @(posedge clk); #1;
    end
    check_output("dec toggle ready", 128'(ready_o), 128'd1);
    check_output("dec toggle data", data_o, {16{8'h63}});

    // start_i during COL2 is dropped: one result, one pulse
    @(negedge clk);
    data_i    = FIPS_IN;
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check_output("busy ready", 128'(ready_o), 128'd1);
    check_output("busy data", data_o, FIPS_OUT);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_o) pulses++;
    end
    check_output("busy extra pulses", 128'(pulses), 128'd0);

    // back-to-back: start accepted in the ready cycle
    apply_stimulus('0, 1'b0, "b2b first", res);
    check_output("b2b first data", res, {16{8'h63}});
    data_i    = CNT_IN;
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check_output("b2b single pulse", 128'(ready_o), 128'd0);
    cycles = 1;
    while (!ready_o && cycles < 10) begin
      check_output("b2b stable", data_o, {16{8'h63}});
      @(posedge clk); #1;
      cycles++;
    end
    check_output("b2b latency", 128'(cycles), 128'd4);
    check_output("b2b second data", data_o, CNT_OUT);

    // reset in COL2 aborts the block without a pulse
    @(negedge clk);
    data_i    = FIPS_IN;
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_output("abort ready", 128'(ready_o), 128'd0);
    check_output("abort data", data_o, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_o) pulses++;
    end
    check_output("abort no pulse", 128'(pulses), 128'd0);
    check_output("abort data held", data_o, '0);
    apply_stimulus(FIPS_IN, 1'b0, "after reset", res);
    check_output("after reset data", res, FIPS_OUT);

    // random blocks, both directions, plus round trip
    prev = '0;
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(rnd, 1'b0, "rand enc", res);
      check_output($sformatf("rand enc %0d", i), res, model(rnd, 1'b0));
      apply_stimulus(res, 1'b1, "rand dec", res2);
      check_output($sformatf("rand dec %0d", i), res2, model(res, 1'b1));
      check_output($sformatf("round trip %0d", i), res2, rnd);
      prev = res2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
